// File: rtl/sync_release_dispatcher_pkg.sv
// Shared synchronization types: release message, tile mask/id and the
// dispatcher FSM state.
package sync_release_dispatcher_pkg;
  localparam int TILE_COUNT = 16;
  localparam int TILE_ID_W  = $clog2(TILE_COUNT);

  typedef logic [TILE_COUNT-1:0] tile_mask_t;
  typedef logic [TILE_ID_W-1:0]  tile_id_t;

  typedef struct packed {
    logic [7:0] barrier_id;
    logic [7:0] epoch;
  } sync_release_message_t;

  typedef enum logic {
    SRD_IDLE = 1'b0,
    SRD_SEND = 1'b1
  } sync_rd_state_t;
endpackage

// File: rtl/sync_release_dispatcher_if.sv
// Release-FIFO / NI-injection bundle; master = dispatcher, slave = environment.
interface sync_release_dispatcher_if #(
  parameter int TILE_COUNT = 16
);
  import sync_release_dispatcher_pkg::*;
  localparam int IDW = (TILE_COUNT > 1) ? $clog2(TILE_COUNT) : 1;

  sync_release_message_t  sc_release_mess;
  logic [TILE_COUNT-1:0]  sc_release_dest_valid;
  logic                   sc_release_valid;
  logic                   rd_release_consumed;
  sync_release_message_t  rd_mess;
  logic [IDW-1:0]         rd_dest;
  logic                   rd_valid;
  logic                   ni_available;
  logic                   rd_release_done;
  logic                   rd_empty_mask_err;

  modport master (
    input  sc_release_mess, sc_release_dest_valid, sc_release_valid, ni_available,
    output rd_release_consumed, rd_mess, rd_dest, rd_valid, rd_release_done,
           rd_empty_mask_err
  );

  modport slave (
    output sc_release_mess, sc_release_dest_valid, sc_release_valid, ni_available,
    input  rd_release_consumed, rd_mess, rd_dest, rd_valid, rd_release_done,
           rd_empty_mask_err
  );
endinterface

// File: rtl/sync_release_dispatcher_encoder.sv
// Lowest-set-bit priority encoder; o_idx is 0 when nothing is set.
module sync_lowest_set_encoder #(
  parameter int WIDTH = 16,
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [IW-1:0]    o_idx,
  output logic             o_found
);
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx   = IW'(i);
        o_found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sync_release_dispatcher.sv
// Turns each release-FIFO entry into one unicast packet per destination tile,
// walking the mask in ascending order under NI back-pressure.
module sync_release_dispatcher
  import sync_release_dispatcher_pkg::*;
#(
  parameter int TILE_ID    = 0,
  parameter int TILE_COUNT = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  sync_release_dispatcher_if.master bus
);
  localparam int IDW = (TILE_COUNT > 1) ? $clog2(TILE_COUNT) : 1;

  if (TILE_ID < 0 || TILE_COUNT < 2) begin : g_param_chk
    $error("sync_release_dispatcher: bad TILE_ID/TILE_COUNT");
  end

  sync_rd_state_t        r_state, w_state_nxt;
  logic [TILE_COUNT-1:0] r_pend, w_pend_nxt, w_clr;
  sync_release_message_t r_msg, w_msg_nxt;
  logic                  r_err, w_err_nxt;
  logic [IDW-1:0]        w_idx;
  logic                  w_found, w_sending, w_accept, w_last, w_consume;

  sync_lowest_set_encoder #(.WIDTH(TILE_COUNT)) u_enc (
    .i_vec   (r_pend),
    .o_idx   (w_idx),
    .o_found (w_found)
  );

  always_comb begin
    w_clr        = '0;
    w_clr[w_idx] = 1'b1;
    w_sending    = (r_state == SRD_SEND) && w_found;
    w_accept     = w_sending && bus.ni_available;
    w_last       = w_accept && ((r_pend & ~w_clr) == '0);
    // A new entry is taken only when nothing of the current one is left.
    w_consume    = bus.sc_release_valid && !reset &&
                   ((r_state == SRD_IDLE) || w_last);

    w_state_nxt = r_state;
    w_pend_nxt  = r_pend;
    w_msg_nxt   = r_msg;
    w_err_nxt   = r_err;
    if (w_accept) begin
      w_pend_nxt = r_pend & ~w_clr;
      if (w_last) w_state_nxt = SRD_IDLE;
    end
    if (w_consume) begin
      w_pend_nxt = bus.sc_release_dest_valid;
      w_msg_nxt  = bus.sc_release_mess;
      if (bus.sc_release_dest_valid != '0) begin
        w_state_nxt = SRD_SEND;
      end else begin
        w_state_nxt = SRD_IDLE;
        w_err_nxt   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= SRD_IDLE;
      r_pend  <= '0;
      r_msg   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      r_msg   <= w_msg_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign bus.rd_valid            = w_sending;
  assign bus.rd_mess             = r_msg;
  assign bus.rd_dest             = w_idx;
  assign bus.rd_release_consumed = w_consume;
  assign bus.rd_release_done     = w_last && !reset;
  assign bus.rd_empty_mask_err   = r_err;

`ifdef DISPLAY_SYNCH_CORE
  always_ff @(posedge clk) begin
    if (!reset && w_accept)
      $display("tile %0d: release barrier %0d -> tile %0d", TILE_ID, r_msg.barrier_id, w_idx);
  end
`endif
endmodule

// File: doc/sync_release_dispatcher.md
# sync_release_dispatcher

Serializes barrier release messages from the synchronization core's release FIFO into one unicast packet per destination tile for the network interface. It sits between the synchronization core release outputs (message, destination mask, valid) and the NI injection port. It dequeues one release entry at a time and walks its destination mask in ascending tile order. It honours NI back-pressure on every packet.

## Interface
- `TILE_ID`, default 0: tile hosting this dispatcher; used only in debug display.
- `TILE_COUNT`, default 16: number of tiles; equals the width of `tile_mask_t`.
- Reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `sc_release_mess`  in  `sync_release_message_t`  head of release FIFO.
- `sc_release_dest_valid`  in  `tile_mask_t`  destination tiles of head entry.
- `sc_release_valid`  in  1  release FIFO non-empty.
- `rd_release_consumed`  out  1  one-cycle dequeue pulse to release FIFO.
- `rd_mess`  out  `sync_release_message_t`  message for current packet.
- `rd_dest`  out  `tile_id_t` (`$clog2(TILE_COUNT)`)  destination tile of current packet.
- `rd_valid`  out  1  packet valid toward NI.
- `ni_available`  in  1  NI accepts the packet this cycle.
- `rd_release_done`  out  1  pulse when the last packet of an entry is accepted.
- `rd_empty_mask_err`  out  1  sticky; set when an entry with an all-zero mask is consumed.

## Operation
- FSM has two states: IDLE and SEND.
- IDLE:
  - If `sc_release_valid` is high, pulse `rd_release_consumed` and latch the message into `msg_q` and the mask into `pend_q`.
  - Go to SEND if the mask is non-zero.
  - If the mask is zero, set `rd_empty_mask_err`, stay in IDLE and do not pulse `rd_release_done`.
- SEND:
  - `rd_valid`=1, `rd_mess`=`msg_q`, `rd_dest`=index of the lowest set bit of `pend_q`.
  - On `rd_valid & ni_available`, clear that bit.
  - If that bit was the last one set: pulse `rd_release_done`.
    - If `sc_release_valid` is also high in that cycle, consume and latch the next entry in the same cycle and stay in SEND; a zero mask here goes to IDLE and sets the error.
    - Otherwise go to IDLE.
- Outputs are stable while `rd_valid` is high and `ni_available` is low; `rd_valid` never drops without acceptance, except on reset.
- `rd_release_consumed` is asserted only in the cases above, never while packets are still pending.
- Reset values: state IDLE; `pend_q`=0; `msg_q`=0; `rd_valid`, `rd_release_consumed`, `rd_release_done`, `rd_empty_mask_err` all 0; `rd_dest`=0.
- Reset mid-SEND: remaining destinations are discarded; the entry was already dequeued and is lost. This is acceptable because reset is system-wide.

## Timing
- Latency: an entry consumed in cycle N drives its first packet in cycle N+1, registered.
- Throughput: one packet per cycle while `ni_available` is high. An entry with k destinations occupies k cycles when there are no stalls.
- Back-to-back entries have no bubble: the next entry is consumed in the cycle the previous last packet is accepted.
- The first entry after IDLE costs one extra cycle.
- `rd_release_consumed` and `rd_release_done` are combinational functions of registered state and the handshake inputs, valid in the handshake cycle.
- `rd_dest` is decoded combinationally from `pend_q`; there is no input-to-output combinational path except via `ni_available` and `sc_release_valid` to the pulses.
- Full mask (all `TILE_COUNT` bits set): packets go to destinations 0…`TILE_COUNT`-1 in order.
- Mask with only the MSB set: `rd_dest`=`TILE_COUNT`-1.

## Structure
- `sync_release_message_t`, `tile_mask_t` and `tile_id_t` come from the shared synchronization defines package. Add an FSM state enum `sync_rd_state_t` there.
- One sub-module: `sync_lowest_set_encoder` (parameter `WIDTH`). Outputs the index of the lowest set bit plus a `found` flag; purely combinational, reused for the mask walk.
- Under `DISPLAY_SYNCH_CORE`, print one line per accepted packet with the barrier ID and destination.

## Test plan
- Mask 4'b1010 (`TILE_COUNT`=4), `ni_available` tied high: one consumed pulse, then packets with dest 1 then 3 in consecutive cycles. Done pulse with the dest-3 packet; back to IDLE.
- Mask 4'b1111, `ni_available` low for 3 cycles at dest 2: `rd_dest`=2 and `rd_mess` held stable for 3 cycles; then dests 2 and 3 issue; exactly 4 accepted packets.
- Two queued entries (masks 4'b0001, 4'b0110), NI always ready:
  - Packets dest 0, 1, 2 in 3 consecutive cycles.
  - Second consumed pulse coincides with the dest-0 acceptance.
  - Two done pulses.
- Entry with mask 0: consumed, no `rd_valid`, `rd_empty_mask_err` goes to 1 and stays 1 until reset.
- Reset asserted one cycle after the first packet of mask 4'b1110: next cycle `rd_valid`=0 and state IDLE; no further packets; the error flag is cleared.
- Random masks and random `ni_available` over 10k entries: the scoreboard checks that the set of destinations per entry equals the mask, that order is ascending, and that there are no duplicates or drops.
